// File: rtl/axi_lite_mon_pkg.sv
// Shared definitions for the AXI4-Lite transaction monitor: error-flag bit
// positions, the error vector type and a response decoder.
package axi_lite_mon_pkg;

    localparam int unsigned ErrBOrphan = 0;
    localparam int unsigned ErrROrphan = 1;
    localparam int unsigned ErrWrOvf   = 2;
    localparam int unsigned ErrRdOvf   = 3;
    localparam int unsigned ErrStable  = 4;
    localparam int unsigned ErrWidth   = 5;

    typedef logic [ErrWidth-1:0] err_t;

    // SLVERR (2'b10) and DECERR (2'b11) count as error responses.
    function automatic logic is_err_resp(input logic [1:0] resp);
        return (resp == 2'b10) || (resp == 2'b11);
    endfunction

endpackage

// File: rtl/axi_lite_mon_pend_cnt.sv
// Outstanding-transaction tracker: up/down counter bounded to [0, MaxVal].
// Flags an underflow (dec seen at zero) and an overflow (net increment at MaxVal);
// in both cases the count holds.
module axi_lite_mon_pend_cnt #(
    parameter int unsigned MaxVal = 8,
    parameter int unsigned Width  = $clog2(MaxVal + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [Width-1:0] cnt_o,
    output logic             underflow_o,
    output logic             overflow_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Error flags look at the value before the edge; a same-cycle inc does not cover a dec at 0.
    always_comb begin
        underflow_o = dec_i && (cnt_q == '0);
        overflow_o  = inc_i && !dec_i && (cnt_q == Width'(MaxVal));
    end

    // Next count: simultaneous inc/dec cancels, out-of-range moves are dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !overflow_o) begin
            cnt_d = cnt_q + Width'(1);
        end else if (dec_i && !inc_i && !underflow_o) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/axi_lite_txn_monitor.sv
// Passive AXI4-Lite transaction monitor: per-channel handshake counters, error-response
// counters, outstanding read/write trackers and sticky protocol error flags.
// Optional feature macro: AXI_LITE_MON_STABILITY_CHECK_EN enables the valid/payload
// stability check on err_o[4]; without it err_o[4] is always 0.
module axi_lite_txn_monitor
    import axi_lite_mon_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned CntWidth  = 32,
    parameter int unsigned MaxTxns   = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         aw_valid_i,
    input  logic                         aw_ready_i,
    input  logic [AddrWidth-1:0]         aw_addr_i,
    input  logic                         w_valid_i,
    input  logic                         w_ready_i,
    input  logic [DataWidth-1:0]         w_data_i,
    input  logic [DataWidth/8-1:0]       w_strb_i,
    input  logic                         b_valid_i,
    input  logic                         b_ready_i,
    input  logic [1:0]                   b_resp_i,
    input  logic                         ar_valid_i,
    input  logic                         ar_ready_i,
    input  logic [AddrWidth-1:0]         ar_addr_i,
    input  logic                         r_valid_i,
    input  logic                         r_ready_i,
    input  logic [1:0]                   r_resp_i,
    output logic [CntWidth-1:0]          aw_cnt_o,
    output logic [CntWidth-1:0]          w_cnt_o,
    output logic [CntWidth-1:0]          b_cnt_o,
    output logic [CntWidth-1:0]          ar_cnt_o,
    output logic [CntWidth-1:0]          r_cnt_o,
    output logic [CntWidth-1:0]          b_err_cnt_o,
    output logic [CntWidth-1:0]          r_err_cnt_o,
    output logic [$clog2(MaxTxns+1)-1:0] wr_pend_o,
    output logic [$clog2(MaxTxns+1)-1:0] rd_pend_o,
    output logic [ErrWidth-1:0]          err_o
);

    localparam int unsigned PendWidth = $clog2(MaxTxns + 1);
    localparam int unsigned NumCnt    = 7;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = aw_valid_i && aw_ready_i;
    assign w_hs  = w_valid_i && w_ready_i;
    assign b_hs  = b_valid_i && b_ready_i;
    assign ar_hs = ar_valid_i && ar_ready_i;
    assign r_hs  = r_valid_i && r_ready_i;

    // Counter order: aw, w, b, ar, r, b_err, r_err.
    logic [NumCnt-1:0]               cnt_inc;
    logic [NumCnt-1:0][CntWidth-1:0] cnt_q, cnt_d;
    err_t                            err_q, err_d, err_set;

    logic [PendWidth-1:0] aw_pend, w_pend, ar_pend;
    logic aw_unf, aw_ovf, w_unf, w_ovf, ar_unf, ar_ovf;
    logic stable_viol;

    axi_lite_mon_pend_cnt #(.MaxVal(MaxTxns), .Width(PendWidth)) u_aw_pend (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (aw_hs),
        .dec_i       (b_hs),
        .cnt_o       (aw_pend),
        .underflow_o (aw_unf),
        .overflow_o  (aw_ovf)
    );

    axi_lite_mon_pend_cnt #(.MaxVal(MaxTxns), .Width(PendWidth)) u_w_pend (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (w_hs),
        .dec_i       (b_hs),
        .cnt_o       (w_pend),
        .underflow_o (w_unf),
        .overflow_o  (w_ovf)
    );

    axi_lite_mon_pend_cnt #(.MaxVal(MaxTxns), .Width(PendWidth)) u_ar_pend (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (ar_hs),
        .dec_i       (r_hs),
        .cnt_o       (ar_pend),
        .underflow_o (ar_unf),
        .overflow_o  (ar_ovf)
    );

`ifdef AXI_LITE_MON_STABILITY_CHECK_EN
    // Per-channel stall flags (valid && !ready) and payload from the previous cycle.
    logic [4:0]             stall_q, stall_d;
    logic [AddrWidth-1:0]   aw_addr_q, ar_addr_q;
    logic [DataWidth-1:0]   w_data_q;
    logic [DataWidth/8-1:0] w_strb_q;
    logic [1:0]             b_resp_q, r_resp_q;

    // A stalled channel must keep valid high and its payload unchanged.
    always_comb begin
        stall_d = {r_valid_i && !r_ready_i, ar_valid_i && !ar_ready_i,
                   b_valid_i && !b_ready_i, w_valid_i && !w_ready_i,
                   aw_valid_i && !aw_ready_i};
        stable_viol =
            (stall_q[0] && (!aw_valid_i || (aw_addr_i != aw_addr_q))) ||
            (stall_q[1] && (!w_valid_i || (w_data_i != w_data_q) || (w_strb_i != w_strb_q))) ||
            (stall_q[2] && (!b_valid_i || (b_resp_i != b_resp_q))) ||
            (stall_q[3] && (!ar_valid_i || (ar_addr_i != ar_addr_q))) ||
            (stall_q[4] && (!r_valid_i || (r_resp_i != r_resp_q)));
    end

    // History registers; not affected by clear_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q   <= '0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_resp_q  <= '0;
            ar_addr_q <= '0;
            r_resp_q  <= '0;
        end else begin
            stall_q   <= stall_d;
            aw_addr_q <= aw_addr_i;
            w_data_q  <= w_data_i;
            w_strb_q  <= w_strb_i;
            b_resp_q  <= b_resp_i;
            ar_addr_q <= ar_addr_i;
            r_resp_q  <= r_resp_i;
        end
    end
`else
    logic unused_payload;
    assign unused_payload = ^{aw_addr_i, w_data_i, w_strb_i, ar_addr_i};
    assign stable_viol    = 1'b0;
`endif

    // Saturating handshake counters and sticky error flags; clear_i wins over increments.
    always_comb begin
        cnt_inc = {r_hs && is_err_resp(r_resp_i), b_hs && is_err_resp(b_resp_i),
                   r_hs, ar_hs, b_hs, w_hs, aw_hs};
        for (int i = 0; i < NumCnt; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear_i) begin
                cnt_d[i] = '0;
            end else if (cnt_inc[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end
        end

        err_set             = '0;
        err_set[ErrBOrphan] = b_hs && (aw_unf || w_unf);
        err_set[ErrROrphan] = r_hs && ar_unf;
        err_set[ErrWrOvf]   = aw_ovf || w_ovf;
        err_set[ErrRdOvf]   = ar_ovf;
        err_set[ErrStable]  = stable_viol;
        err_d = clear_i ? '0 : (err_q | err_set);
    end

    // Counter and error flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign aw_cnt_o    = cnt_q[0];
    assign w_cnt_o     = cnt_q[1];
    assign b_cnt_o     = cnt_q[2];
    assign ar_cnt_o    = cnt_q[3];
    assign r_cnt_o     = cnt_q[4];
    assign b_err_cnt_o = cnt_q[5];
    assign r_err_cnt_o = cnt_q[6];
    assign wr_pend_o   = aw_pend;
    assign rd_pend_o   = ar_pend;
    assign err_o       = err_q;

endmodule

// File: tb/tb_axi_lite_txn_monitor.sv
// Directed bench for axi_lite_txn_monitor (CntWidth=4 to reach saturation quickly).
module tb_axi_lite_txn_monitor;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned MT = 8;
    localparam int unsigned PW = $clog2(MT + 1);

    logic clk = 1'b0;
    logic rst_ni, clear_i;
    logic aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic ar_valid, ar_ready, r_valid, r_ready;
    logic [AW-1:0] aw_addr, ar_addr;
    logic [DW-1:0] w_data;
    logic [DW/8-1:0] w_strb;
    logic [1:0] b_resp, r_resp;
    logic [CW-1:0] aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, b_err_cnt, r_err_cnt;
    logic [PW-1:0] wr_pend, rd_pend;
    logic [4:0] err;
    logic [4:0] exp_stable;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_lite_txn_monitor #(
        .AddrWidth(AW), .DataWidth(DW), .CntWidth(CW), .MaxTxns(MT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_addr_i(aw_addr),
        .w_valid_i(w_valid), .w_ready_i(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
        .b_valid_i(b_valid), .b_ready_i(b_ready), .b_resp_i(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_i(ar_ready), .ar_addr_i(ar_addr),
        .r_valid_i(r_valid), .r_ready_i(r_ready), .r_resp_i(r_resp),
        .aw_cnt_o(aw_cnt), .w_cnt_o(w_cnt), .b_cnt_o(b_cnt), .ar_cnt_o(ar_cnt),
        .r_cnt_o(r_cnt), .b_err_cnt_o(b_err_cnt), .r_err_cnt_o(r_err_cnt),
        .wr_pend_o(wr_pend), .rd_pend_o(rd_pend), .err_o(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive full handshakes on the selected channels for one cycle.
    task automatic drive(input logic aw, input logic w, input logic b, input logic ar,
                         input logic r, input logic [1:0] br, input logic [1:0] rr);
        aw_valid = aw; aw_ready = aw;
        w_valid  = w;  w_ready  = w;
        b_valid  = b;  b_ready  = b;  b_resp = br;
        ar_valid = ar; ar_ready = ar;
        r_valid  = r;  r_ready  = r;  r_resp = rr;
        tick();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 2'b00, 2'b00);
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        idle();
        clear_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        aw_valid = 0; aw_ready = 0; w_valid = 0; w_ready = 0; b_valid = 0; b_ready = 0;
        ar_valid = 0; ar_ready = 0; r_valid = 0; r_ready = 0;
        b_resp = 0; r_resp = 0; aw_addr = 0; ar_addr = 0; w_data = 0; w_strb = 0;
        clear_i = 0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_ni = 1'b0;
        tick();
        checks++; if (aw_cnt !== 4'd0) begin failures++; $display("FAIL reset_aw got=%0d exp=0", aw_cnt); end
        checks++; if (b_cnt !== 4'd0) begin failures++; $display("FAIL reset_b got=%0d exp=0", b_cnt); end
        checks++; if (wr_pend !== 4'd0) begin failures++; $display("FAIL reset_wrpend got=%0d exp=0", wr_pend); end
        checks++; if (err !== 5'd0) begin failures++; $display("FAIL reset_err got=%b exp=00000", err); end
        rst_ni = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 2'b00, 2'b00);
        checks++; if (wr_pend !== 4'd4) begin failures++; $display("FAIL basic_wrpend4 got=%0d exp=4", wr_pend); end
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 2'b00, 2'b00);
        checks++; if (rd_pend !== 4'd3) begin failures++; $display("FAIL basic_rdpend3 got=%0d exp=3", rd_pend); end
        drive(0, 0, 0, 0, 1, 2'b00, 2'b00);
        drive(0, 0, 0, 0, 1, 2'b00, 2'b10);
        drive(0, 0, 0, 0, 1, 2'b00, 2'b00);
        idle();
        checks++; if (aw_cnt !== 4'd4) begin failures++; $display("FAIL basic_aw got=%0d exp=4", aw_cnt); end
        checks++; if (w_cnt !== 4'd4) begin failures++; $display("FAIL basic_w got=%0d exp=4", w_cnt); end
        checks++; if (b_cnt !== 4'd4) begin failures++; $display("FAIL basic_b got=%0d exp=4", b_cnt); end
        checks++; if (ar_cnt !== 4'd3) begin failures++; $display("FAIL basic_ar got=%0d exp=3", ar_cnt); end
        checks++; if (r_cnt !== 4'd3) begin failures++; $display("FAIL basic_r got=%0d exp=3", r_cnt); end
        checks++; if (r_err_cnt !== 4'd1) begin failures++; $display("FAIL basic_rerr got=%0d exp=1", r_err_cnt); end
        checks++; if (b_err_cnt !== 4'd0) begin failures++; $display("FAIL basic_berr got=%0d exp=0", b_err_cnt); end
        checks++; if (wr_pend !== 4'd0) begin failures++; $display("FAIL basic_wrpend got=%0d exp=0", wr_pend); end
        checks++; if (rd_pend !== 4'd0) begin failures++; $display("FAIL basic_rdpend got=%0d exp=0", rd_pend); end
        checks++; if (err !== 5'd0) begin failures++; $display("FAIL basic_err got=%b exp=00000", err); end
    endtask

    task automatic test_orphan_b();
        do_reset();
        drive(0, 0, 1, 0, 0, 2'b00, 2'b00);
        checks++; if (err !== 5'b00001) begin failures++; $display("FAIL orphan_err got=%b exp=00001", err); end
        checks++; if (wr_pend !== 4'd0) begin failures++; $display("FAIL orphan_wrpend got=%0d exp=0", wr_pend); end
        checks++; if (b_cnt !== 4'd1) begin failures++; $display("FAIL orphan_bcnt got=%0d exp=1", b_cnt); end
        pulse_clear();
        checks++; if (err !== 5'd0) begin failures++; $display("FAIL clear_err got=%b exp=00000", err); end
        checks++; if (b_cnt !== 4'd0) begin failures++; $display("FAIL clear_bcnt got=%0d exp=0", b_cnt); end
        // Same-cycle AW/W does not cover a B at zero; DECERR counts as error response.
        drive(1, 1, 1, 0, 0, 2'b11, 2'b00);
        checks++; if (err !== 5'b00001) begin failures++; $display("FAIL samecyc_err got=%b exp=00001", err); end
        checks++; if (wr_pend !== 4'd0) begin failures++; $display("FAIL samecyc_wrpend got=%0d exp=0", wr_pend); end
        checks++; if (b_err_cnt !== 4'd1) begin failures++; $display("FAIL samecyc_berr got=%0d exp=1", b_err_cnt); end
        checks++; if (aw_cnt !== 4'd1) begin failures++; $display("FAIL samecyc_aw got=%0d exp=1", aw_cnt); end
        drive(0, 0, 0, 0, 1, 2'b00, 2'b00);
        checks++; if (err !== 5'b00011) begin failures++; $display("FAIL orphan_r_err got=%b exp=00011", err); end
        checks++; if (rd_pend !== 4'd0) begin failures++; $display("FAIL orphan_r_rdpend got=%0d exp=0", rd_pend); end
        pulse_clear();
    endtask

    task automatic test_rd_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 0, 2'b00, 2'b00);
        checks++; if (rd_pend !== 4'd8) begin failures++; $display("FAIL ovf_full got=%0d exp=8", rd_pend); end
        drive(0, 0, 0, 1, 1, 2'b00, 2'b00);
        checks++; if (err !== 5'd0) begin failures++; $display("FAIL ovf_updown_err got=%b exp=00000", err); end
        checks++; if (rd_pend !== 4'd8) begin failures++; $display("FAIL ovf_updown_pend got=%0d exp=8", rd_pend); end
        drive(0, 0, 0, 1, 0, 2'b00, 2'b00);
        checks++; if (err !== 5'b01000) begin failures++; $display("FAIL ovf_err got=%b exp=01000", err); end
        checks++; if (rd_pend !== 4'd8) begin failures++; $display("FAIL ovf_hold got=%0d exp=8", rd_pend); end
        checks++; if (ar_cnt !== 4'd10) begin failures++; $display("FAIL ovf_arcnt got=%0d exp=10", ar_cnt); end
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, 2'b00, 2'b00);
        checks++; if (rd_pend !== 4'd0) begin failures++; $display("FAIL ovf_drain got=%0d exp=0", rd_pend); end
        checks++; if (r_cnt !== 4'd9) begin failures++; $display("FAIL ovf_rcnt got=%0d exp=9", r_cnt); end
        checks++; if (err !== 5'b01000) begin failures++; $display("FAIL ovf_sticky got=%b exp=01000", err); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0, 2'b00, 2'b00);
        checks++; if (aw_cnt !== 4'd15) begin failures++; $display("FAIL sat_aw got=%0d exp=15", aw_cnt); end
        checks++; if (wr_pend !== 4'd8) begin failures++; $display("FAIL sat_wrpend got=%0d exp=8", wr_pend); end
        checks++; if (err !== 5'b00100) begin failures++; $display("FAIL sat_err got=%b exp=00100", err); end
        // Clear overrides a same-cycle handshake and overflow; trackers untouched.
        clear_i = 1'b1;
        drive(1, 0, 0, 0, 0, 2'b00, 2'b00);
        clear_i = 1'b0;
        checks++; if (aw_cnt !== 4'd0) begin failures++; $display("FAIL clrovr_aw got=%0d exp=0", aw_cnt); end
        checks++; if (err !== 5'd0) begin failures++; $display("FAIL clrovr_err got=%b exp=00000", err); end
        checks++; if (wr_pend !== 4'd8) begin failures++; $display("FAIL clrovr_wrpend got=%0d exp=8", wr_pend); end
    endtask

    task automatic test_stability();
        do_reset();
`ifdef AXI_LITE_MON_STABILITY_CHECK_EN
        exp_stable = 5'b10000;
`else
        exp_stable = 5'b00000;
`endif
        aw_valid = 1'b1; aw_ready = 1'b0; aw_addr = 32'h100;
        tick();
        aw_addr = 32'h104;
        tick();
        aw_valid = 1'b0;
        tick();
        checks++; if (err !== exp_stable) begin failures++; $display("FAIL stable_err got=%b exp=%b", err, exp_stable); end
        checks++; if (aw_cnt !== 4'd0) begin failures++; $display("FAIL stable_aw got=%0d exp=0", aw_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 2'b00, 2'b00);
        checks++; if (wr_pend !== 4'd3) begin failures++; $display("FAIL ar_pre_wrpend got=%0d exp=3", wr_pend); end
        aw_valid = 1; aw_ready = 1; w_valid = 1; w_ready = 1;
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (wr_pend !== 4'd0) begin failures++; $display("FAIL async_wrpend got=%0d exp=0", wr_pend); end
        checks++; if (aw_cnt !== 4'd0) begin failures++; $display("FAIL async_aw got=%0d exp=0", aw_cnt); end
        checks++; if (w_cnt !== 4'd0) begin failures++; $display("FAIL async_w got=%0d exp=0", w_cnt); end
        tick();
        tick();
        checks++; if (aw_cnt !== 4'd0) begin failures++; $display("FAIL inrst_aw got=%0d exp=0", aw_cnt); end
        rst_ni = 1'b1;
        drive(0, 0, 1, 0, 0, 2'b00, 2'b00);
        checks++; if (err !== 5'b00001) begin failures++; $display("FAIL postrst_err got=%b exp=00001", err); end
        checks++; if (wr_pend !== 4'd0) begin failures++; $display("FAIL postrst_wrpend got=%0d exp=0", wr_pend); end
        checks++; if (aw_cnt !== 4'd0) begin failures++; $display("FAIL postrst_aw got=%0d exp=0", aw_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_orphan_b();
        test_rd_overflow();
        test_saturation();
        test_stability();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_txn_monitor.md
AXI_LITE_TXN_MONITOR -- requirements
Module: axi_lite_txn_monitor

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, meaning AXI4-Lite address width.
REQ-002 SHALL have parameter DataWidth, default 32, meaning AXI4-Lite data width; strobe width is DataWidth/8.
REQ-003 SHALL have parameter CntWidth, default 32, meaning width of each beat/error counter.
REQ-004 SHALL have parameter MaxTxns, default 8, meaning legal outstanding transactions per direction; PendWidth = $clog2(MaxTxns+1).
REQ-005 SHALL have ports: clk_i in 1 clock; rst_ni in 1 asynchronous active-low reset.
REQ-006 SHALL have ports: clear_i in 1 synchronous clear of counters and errors.
REQ-007 SHALL have tap inputs: aw_valid_i, aw_ready_i 1 each; aw_addr_i AddrWidth; w_valid_i, w_ready_i 1 each; w_data_i DataWidth; w_strb_i DataWidth/8; b_valid_i, b_ready_i 1 each; b_resp_i 2.
REQ-008 SHALL have tap inputs: ar_valid_i, ar_ready_i 1 each; ar_addr_i AddrWidth; r_valid_i, r_ready_i 1 each; r_resp_i 2.
REQ-009 SHALL have outputs aw_cnt_o, w_cnt_o, b_cnt_o, ar_cnt_o, r_cnt_o, each CntWidth: handshake counts per channel.
REQ-010 SHALL have outputs b_err_cnt_o, r_err_cnt_o, each CntWidth: handshakes with resp SLVERR or DECERR.
REQ-011 SHALL have outputs wr_pend_o, rd_pend_o, each PendWidth: outstanding writes (AW accepted, B not) and reads.
REQ-012 SHALL have output err_o, 5 bits, sticky error flags.

Function
REQ-013 SHALL be purely passive; no tap input is ever driven or altered.
REQ-014 A handshake SHALL be valid&&ready sampled at rising clk_i; every output SHALL be registered and reflect it one cycle later.
REQ-015 Each counter SHALL increment by 1 per handshake and saturate at all-ones (no wrap).
REQ-016 Three pending trackers (AW, W, AR) SHALL count up on own handshake and down on B (AW, W) or R (AR); simultaneous up and down leaves value unchanged.
REQ-017 wr_pend_o SHALL equal AW tracker; rd_pend_o SHALL equal AR tracker.
REQ-018 err_o[0] SHALL set on a B handshake when AW or W tracker is 0 before the edge (same-cycle AW/W does not cover it); that tracker stays 0.
REQ-019 err_o[1] SHALL set on an R handshake when AR tracker is 0; tracker stays 0.
REQ-020 err_o[2] SHALL set when AW or W tracker is MaxTxns and it would increment without simultaneous B; tracker holds MaxTxns.
REQ-021 err_o[3] SHALL set under the same condition for the AR tracker.
REQ-022 err_o bits SHALL stay set until clear_i or reset.
REQ-023 clear_i SHALL zero all counters and err_o on the edge it is sampled, overriding any same-cycle increment; pending trackers SHALL NOT be affected.

Reset
REQ-024 On rst_ni low, all counters, trackers and err_o SHALL go to 0 immediately, independent of clk_i.
REQ-025 Handshakes SHALL be ignored while rst_ni is low; first counted edge is the first rising clk_i after release.

Configuration
REQ-026 With AXI_LITE_MON_STABILITY_CHECK_EN defined, err_o[4] SHALL set when any valid was high with ready low and next cycle that valid is low, or aw_addr_i, w_data_i, w_strb_i, ar_addr_i, b_resp_i or r_resp_i of that stalled channel changed.
REQ-027 Without AXI_LITE_MON_STABILITY_CHECK_EN, err_o[4] SHALL be constant 0 and no payload history registers SHALL exist.

Structure
REQ-028 Package axi_lite_mon_pkg SHALL hold err_o bit-index constants (ErrBOrphan=0, ErrROrphan=1, ErrWrOvf=2, ErrRdOvf=3, ErrStable=4) and typedef err_t (5-bit).
REQ-029 Sub-module axi_lite_mon_pend_cnt (parametrised up/down counter, inc/dec in, underflow/overflow out) SHALL be instantiated three times.

Verification
REQ-030 4 AW, 4 W, 4 B OKAY, 3 AR, 3 R (one SLVERR) -> aw/w/b=4, ar/r=3, r_err=1, b_err=0, pends 0, err_o=0.
REQ-031 B handshake after reset with no AW -> err_o[0]=1 next cycle, wr_pend_o=0; clear_i one cycle -> err_o=0, counters 0.
REQ-032 MaxTxns=8, 9 AR handshakes no R -> rd_pend_o=8, err_o[3]=1; then 8 R -> rd_pend_o=0.
REQ-033 CntWidth=4, 20 AW handshakes -> aw_cnt_o=15 held.
REQ-034 Macro defined: aw_valid high, ready low, aw_addr 0x100 then 0x104 -> err_o[4]=1; macro undefined -> err_o[4]=0.
REQ-035 rst_ni low mid-traffic with wr_pend_o=3 -> all outputs 0 asynchronously; first B after release -> err_o[0]=1.
